multicycle_control: RTL

- Sequenced successor to the single-cycle control decoder, for the multicycle RV32I core variant.
- Takes the decoded `opcode_out_t` from the instruction register and walks each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory port with a req/ack handshake.
- Issues per-state datapath strobes, watches for memory timeouts, handles halt on system instructions and counts retired instructions.

---
 rtl/multicycle_control.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Sequencing control for the multicycle RV32I core: walks each decoded instruction
// through FETCH/DECODE/EXEC/MEM/WB over a shared req/ack memory port.
package mc_pkg;
  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ECALL, OP_EBREAK
  } opcode_out_t;

  typedef enum logic [3:0] {
    MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_t;

  typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PC4} reg_wr_src_t;
  typedef enum logic {SRC1_REG1, SRC1_PC} alu_src1_t;
  typedef enum logic {SRC2_REG2, SRC2_IMM} alu_src2_t;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
  } alu_op_t;

  typedef enum logic [2:0] {BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} comp_op_t;
endpackage

module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT     = 16,
  parameter bit          HALT_ON_SYSTEM = 1'b1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  opcode_out_t       opcode_in,
  input  logic              branch_taken,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  output mem_op_t           mem_ctrl,
  output logic              ir_we,
  output logic              pc_we,
  output logic              pc_src_ctrl,
  output logic              reg_do_write_ctrl,
  output reg_wr_src_t       reg_wr_src_ctrl,
  output alu_src1_t         alu_src1_ctrl,
  output alu_src2_t         alu_src2_ctrl,
  output alu_op_t           alu_ctrl,
  output comp_op_t          comp_ctrl,
  output logic              instr_retired,
  output logic [CNT_W-1:0]  instret_count,
  output logic              halted,
  output logic              mem_error
);

  localparam int unsigned WAIT_W    = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam int unsigned WAIT_LAST = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [CNT_W-1:0]   r_instret;
  logic               w_retire;
  logic               w_timeout;
  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch;
  logic w_is_jump, w_is_lui, w_is_auipc, w_is_jal, w_is_system, w_is_exec;

  function automatic alu_op_t f_alu_op(input opcode_out_t op);
    case (op)
      OP_SUB:            return ALU_SUB;
      OP_SLL,  OP_SLLI:  return ALU_SLL;
      OP_SLT,  OP_SLTI:  return ALU_SLT;
      OP_SLTU, OP_SLTIU: return ALU_SLTU;
      OP_XOR,  OP_XORI:  return ALU_XOR;
      OP_SRL,  OP_SRLI:  return ALU_SRL;
      OP_SRA,  OP_SRAI:  return ALU_SRA;
      OP_OR,   OP_ORI:   return ALU_OR;
      OP_AND,  OP_ANDI:  return ALU_AND;
      OP_LUI:            return ALU_LUI;
      default:           return ALU_ADD;
    endcase
  endfunction

  function automatic comp_op_t f_comp_op(input opcode_out_t op);
    case (op)
      OP_BEQ:  return BR_EQ;
      OP_BNE:  return BR_NE;
      OP_BLT:  return BR_LT;
      OP_BGE:  return BR_GE;
      OP_BLTU: return BR_LTU;
      OP_BGEU: return BR_GEU;
      default: return BR_NOP;
    endcase
  endfunction

  function automatic mem_op_t f_mem_op(input opcode_out_t op);
    case (op)
      OP_LB:   return MEM_LB;
      OP_LH:   return MEM_LH;
      OP_LW:   return MEM_LW;
      OP_LBU:  return MEM_LBU;
      OP_LHU:  return MEM_LHU;
      OP_SB:   return MEM_SB;
      OP_SH:   return MEM_SH;
      OP_SW:   return MEM_SW;
      default: return MEM_NOP;
    endcase
  endfunction

  // Instruction class decode
  assign w_is_r      = opcode_in inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                                         OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
  assign w_is_i      = opcode_in inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                                         OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
  assign w_is_load   = opcode_in inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign w_is_store  = opcode_in inside {OP_SB, OP_SH, OP_SW};
  assign w_is_branch = opcode_in inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  assign w_is_jal    = (opcode_in == OP_JAL);
  assign w_is_jump   = w_is_jal || (opcode_in == OP_JALR);
  assign w_is_lui    = (opcode_in == OP_LUI);
  assign w_is_auipc  = (opcode_in == OP_AUIPC);
  assign w_is_system = opcode_in inside {OP_ECALL, OP_EBREAK};
  assign w_is_exec   = w_is_r || w_is_i || w_is_load || w_is_store || w_is_branch ||
                       w_is_jump || w_is_lui || w_is_auipc;

  // Ack in the final allowed cycle takes priority over the timeout
  assign w_timeout = (WAIT_LIMIT != 0) && !mem_ack && (r_wait == WAIT_W'(WAIT_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state || mem_ack) r_wait <= '0;
      else if (mem_req)                       r_wait <= r_wait + WAIT_W'(1);
      if (w_retire) r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Next state and strobes; everything is forced to defaults while rst is high
  always_comb begin
    w_state_next      = r_state;
    w_retire          = 1'b0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr_sel      = 1'b0;
    mem_ctrl          = MEM_NOP;
    ir_we             = 1'b0;
    pc_we             = 1'b0;
    pc_src_ctrl       = 1'b0;
    reg_do_write_ctrl = 1'b0;
    reg_wr_src_ctrl   = WRSRC_ALURES;
    alu_src1_ctrl     = SRC1_REG1;
    alu_src2_ctrl     = SRC2_REG2;
    alu_ctrl          = ALU_NOP;
    comp_ctrl         = BR_NOP;
    halted            = 1'b0;
    mem_error         = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_ctrl = MEM_LW;
          if (mem_ack) begin
            ir_we        = 1'b1;
            w_state_next = S_DECODE;
          end else if (w_timeout) begin
            w_state_next = S_ERROR;
          end
        end
        S_DECODE: begin
          if (w_is_exec) begin
            w_state_next = S_EXEC;
          end else if (w_is_system && HALT_ON_SYSTEM) begin
            w_state_next = S_HALT;
          end else begin
            pc_we        = 1'b1;
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_src1_ctrl = (w_is_branch || w_is_jal || w_is_auipc) ? SRC1_PC : SRC1_REG1;
          alu_src2_ctrl = w_is_r ? SRC2_REG2 : SRC2_IMM;
          alu_ctrl      = f_alu_op(opcode_in);
          if (w_is_branch) begin
            comp_ctrl    = f_comp_op(opcode_in);
            pc_we        = 1'b1;
            pc_src_ctrl  = branch_taken;
            w_retire     = 1'b1;
            w_state_next = S_FETCH;
          end else if (w_is_load || w_is_store) begin
            w_state_next = S_MEM;
          end else begin
            w_state_next = S_WB;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = w_is_store;
          mem_ctrl     = f_mem_op(opcode_in);
          if (mem_ack) begin
            if (w_is_store) begin
              pc_we        = 1'b1;
              w_retire     = 1'b1;
              w_state_next = S_FETCH;
            end else begin
              w_state_next = S_WB;
            end
          end else if (w_timeout) begin
            w_state_next = S_ERROR;
          end
        end
        S_WB: begin
          reg_do_write_ctrl = 1'b1;
          reg_wr_src_ctrl   = w_is_load ? WRSRC_MEMREAD : (w_is_jump ? WRSRC_PC4 : WRSRC_ALURES);
          pc_we             = 1'b1;
          pc_src_ctrl       = w_is_jump;
          w_retire          = 1'b1;
          w_state_next      = S_FETCH;
        end
        S_HALT:  halted    = 1'b1;
        S_ERROR: mem_error = 1'b1;
        default: w_state_next = S_FETCH;
      endcase
    end
  end

  assign instr_retired = w_retire;
  assign instret_count = r_instret;

endmodule
